// File: rtl/pipeline_hazard_ctrl_if.sv
// Hazard-control bundle between the pipeline datapath and the stall/flush sequencer.
// The datapath side is the master; the sequencer is the slave.
interface pipeline_hazard_ctrl_if #(
    parameter int unsigned CNT_WIDTH = 32
);
    // Hazard sources observed in ID/EX/MEM
    logic [4:0]           id_rs1;
    logic [4:0]           id_rs2;
    logic                 id_useRs1;
    logic                 id_useRs2;
    logic                 ex_memRead;
    logic [4:0]           ex_rd;
    logic                 ex_mcOp;
    logic                 ex_branchTaken;
    logic                 mem_access;
    logic                 dmem_ready;
    logic                 mc_done;

    // Pipeline register control
    logic                 pc_en;
    logic                 ifid_en;
    logic                 idex_en;
    logic                 exmem_en;
    logic                 memwb_en;
    logic                 ifid_flush;
    logic                 idex_flush;
    logic                 exmem_flush;
    logic                 mc_start;
    logic [CNT_WIDTH-1:0] stall_count;

    modport master (
        output id_rs1, id_rs2, id_useRs1, id_useRs2, ex_memRead, ex_rd, ex_mcOp,
               ex_branchTaken, mem_access, dmem_ready, mc_done,
        input  pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_flush, idex_flush,
               exmem_flush, mc_start, stall_count
    );

    modport slave (
        input  id_rs1, id_rs2, id_useRs1, id_useRs2, ex_memRead, ex_rd, ex_mcOp,
               ex_branchTaken, mem_access, dmem_ready, mc_done,
        output pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_flush, idex_flush,
               exmem_flush, mc_start, stall_count
    );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: load-use bubbles, branch squashes,
// multi-cycle EX ops and data-memory wait states. Forwarding handles everything else.
module pipeline_hazard_ctrl #(
    parameter int unsigned CNT_WIDTH = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    pipeline_hazard_ctrl_if.slave  bus
);

    typedef enum logic {StRun, StMcBusy} state_e;

    state_e               state_q, state_d;
    logic                 done_pend_q, done_pend_d;
    logic [CNT_WIDTH-1:0] stall_count_q, stall_count_d;

    logic memstall;
    logic loaduse;
    logic done;

    logic pc_en, ifid_en, idex_en, exmem_en, memwb_en;
    logic ifid_flush, idex_flush, exmem_flush, mc_start;

    assign memstall = bus.mem_access & ~bus.dmem_ready;
    assign loaduse  = bus.ex_memRead & (bus.ex_rd != 5'd0) &
                      ((bus.id_useRs1 & (bus.id_rs1 == bus.ex_rd)) |
                       (bus.id_useRs2 & (bus.id_rs2 == bus.ex_rd)));
    // A completion seen while frozen by memory is remembered in done_pend.
    assign done     = bus.mc_done | done_pend_q;

    // Next-state and per-stage enable/flush decode
    always_comb begin
        state_d     = state_q;
        done_pend_d = done_pend_q;
        pc_en       = 1'b1;
        ifid_en     = 1'b1;
        idex_en     = 1'b1;
        exmem_en    = 1'b1;
        memwb_en    = 1'b1;
        ifid_flush  = 1'b0;
        idex_flush  = 1'b0;
        exmem_flush = 1'b0;
        mc_start    = 1'b0;

        if (rst) begin
            pc_en       = 1'b0;
            ifid_en     = 1'b0;
            idex_en     = 1'b0;
            exmem_en    = 1'b0;
            memwb_en    = 1'b0;
            ifid_flush  = 1'b1;
            idex_flush  = 1'b1;
            exmem_flush = 1'b1;
        end else if (memstall) begin
            // Memory wait freezes everything, regardless of state.
            pc_en    = 1'b0;
            ifid_en  = 1'b0;
            idex_en  = 1'b0;
            exmem_en = 1'b0;
            memwb_en = 1'b0;
            if (state_q == StMcBusy && bus.mc_done) begin
                done_pend_d = 1'b1;
            end
        end else begin
            unique case (state_q)
                StRun: begin
                    if (bus.ex_mcOp) begin
                        mc_start    = 1'b1;
                        pc_en       = 1'b0;
                        ifid_en     = 1'b0;
                        idex_en     = 1'b0;
                        exmem_flush = 1'b1;
                        state_d     = StMcBusy;
                    end else if (bus.ex_branchTaken) begin
                        // Squashes the ID instruction, so a load-use there is moot.
                        ifid_flush = 1'b1;
                        idex_flush = 1'b1;
                    end else if (loaduse) begin
                        pc_en      = 1'b0;
                        ifid_en    = 1'b0;
                        idex_flush = 1'b1;
                    end
                end
                StMcBusy: begin
                    if (!done) begin
                        pc_en       = 1'b0;
                        ifid_en     = 1'b0;
                        idex_en     = 1'b0;
                        exmem_flush = 1'b1;
                    end else begin
                        // Release: EX/MEM captures the result; ex_mcOp still high is ignored.
                        done_pend_d = 1'b0;
                        state_d     = StRun;
                    end
                end
                default: state_d = StRun;
            endcase
        end
    end

    // Saturating count of cycles with the PC held
    always_comb begin
        stall_count_d = stall_count_q;
        if (!pc_en && (stall_count_q != {CNT_WIDTH{1'b1}})) begin
            stall_count_d = stall_count_q + 1'b1;
        end
    end

    // State registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= StRun;
            done_pend_q   <= 1'b0;
            stall_count_q <= '0;
        end else begin
            state_q       <= state_d;
            done_pend_q   <= done_pend_d;
            stall_count_q <= stall_count_d;
        end
    end

    assign bus.pc_en       = pc_en;
    assign bus.ifid_en     = ifid_en;
    assign bus.idex_en     = idex_en;
    assign bus.exmem_en    = exmem_en;
    assign bus.memwb_en    = memwb_en;
    assign bus.ifid_flush  = ifid_flush;
    assign bus.idex_flush  = idex_flush;
    assign bus.exmem_flush = exmem_flush;
    assign bus.mc_start    = mc_start;
    assign bus.stall_count = stall_count_q;

endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
- Central stall/flush sequencer for the 5-stage RV32 pipeline (IF/ID/EX/MEM/WB).
- Detects load-use hazards, taken-branch redirects, multi-cycle EX ops (mul/div) and data-memory wait states.
- Drives per-stage pipeline-register enables and flushes, plus the start handshake of the multi-cycle unit.
- Runs alongside data_forwarding, covering only the hazards that forwarding cannot resolve.

Parameters:
- CNT_WIDTH, 32, width of the saturating stall-cycle counter.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- id_rs1, id_rs2  in  regName_t (5)  source registers of the instruction in ID.
- id_useRs1, id_useRs2  in  1  ID instruction actually reads rs1 / rs2.
- ex_memRead  in  1  EX instruction is a load.
- ex_rd  in  regName_t (5)  destination register of the EX instruction.
- ex_mcOp  in  1  EX instruction needs the multi-cycle unit.
- ex_branchTaken  in  1  EX resolved a taken branch or jump (PC redirect).
- mem_access  in  1  MEM instruction is a load or store.
- dmem_ready  in  1  data memory completes the access this cycle.
- mc_done  in  1  multi-cycle unit result valid (1-cycle pulse).
- pc_en, ifid_en, idex_en, exmem_en, memwb_en  out  1 each  register load enables.
- ifid_flush, idex_flush, exmem_flush  out  1 each  load a bubble (NOP) into that register.
- mc_start  out  1  1-cycle start pulse to the multi-cycle unit.
- stall_count  out  CNT_WIDTH  cycles with pc_en==0 since reset, saturating.

Behaviour:
- Reset (rst=1 at an edge):
  - state <= RUN, done_pend <= 0, stall_count <= 0.
  - While rst=1: all enables 0, all flushes 1, mc_start 0.
  - A reset during MC_BUSY abandons the op; a late mc_done is then ignored because state is RUN.
- Outputs are combinational from state, done_pend and inputs. Enables default to 1, flushes and mc_start to 0.
- Condition memstall = mem_access & ~dmem_ready.
- Condition loaduse = ex_memRead & (ex_rd!=0) & ((id_useRs1 & id_rs1==ex_rd) | (id_useRs2 & id_rs2==ex_rd)).
- State RUN, first matching rule wins:
  1. memstall: all five enables 0, no flushes (full freeze).
  2. ex_mcOp: mc_start=1; pc_en, ifid_en, idex_en = 0; exmem_flush=1; memwb_en=1; next state MC_BUSY.
  3. ex_branchTaken: all enables 1; ifid_flush=1 and idex_flush=1. Overrides loaduse, since the ID instruction is squashed.
  4. loaduse: pc_en=0, ifid_en=0, idex_flush=1 (one bubble); exmem_en=1, memwb_en=1.
  5. Otherwise: all enables 1.
- State MC_BUSY:
  - Define done = mc_done | done_pend.
  - memstall & mc_done: done_pend <= 1; full freeze.
  - memstall, otherwise: full freeze.
  - ~memstall & ~done: same outputs as RUN rule 2 but mc_start=0 (EX held, bubbles into EX/MEM).
  - ~memstall & done: all enables 1, no flush (EX/MEM captures the result); done_pend <= 0; next state RUN.
  - ex_mcOp is still 1 in that release cycle and does not retrigger.
- Single-op latency: mc_start at cycle t; the earliest release is t+1 if mc_done=1 at t+1. mc_done at t is ignored.
- Cycle counts:
  - Load-use costs exactly 1 stall cycle.
  - Taken branch costs 2 flushed slots and 0 stall cycles.
  - An mc op with mc_done at t+k costs k stall cycles (t..t+k-1), assuming no memstall.
- stall_count increments every cycle with rst=0 and pc_en=0, and holds at 2^CNT_WIDTH-1.

Test Plan:
- Load-use: ex_memRead=1, ex_rd=5, id_rs2=5, id_useRs2=1 → for exactly 1 cycle pc_en=0, ifid_en=0, idex_flush=1; stall_count goes 0→1. With ex_rd=0 instead → no stall.
- Branch vs load-use: ex_branchTaken=1 with the loaduse condition true → pc_en=1, ifid_flush=1, idex_flush=1, no stall; stall_count unchanged.
- Mul/div: ex_mcOp=1 at cycle 10, mc_done=1 at cycle 14 → mc_start high only in cycle 10; pc_en=0 in cycles 10–13 with exmem_flush=1; release in cycle 14; state RUN in cycle 15; stall_count=4.
- Mem wait during mc: memstall in cycles 12–15 and mc_done in cycle 13 → full freeze in 12–15; release in cycle 16 via done_pend; no second mc_start.
- Mem wait priority: memstall=1 for 3 cycles together with ex_mcOp=1 and ex_branchTaken=1 → all enables 0 and no mc_start for 3 cycles; mc_start asserts in the 4th cycle.
- Reset: rst=1 while in MC_BUSY, then mc_done=1 one cycle after rst drops → state RUN, all flushes 1 during reset, no release action, stall_count=0.
